// File: rtl/vec_exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : vec_exec_pipe
//  Purpose  : Vector execute stage. LANES lanes of WIDTH bits either apply
//             one elementwise ALU op (ADD/SUB/AND/OR/XOR) or reduce the whole
//             vector through a pipelined tree (SUM, signed MAX, signed MIN).
//             Every op has a fixed latency of LAT = $clog2(LANES)+1 cycles.
//             Valid/ready backpressure stalls the entire pipeline at once.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous reset, active low
//             in_valid   - operation presented
//             in_ready   - pipeline can accept this cycle
//             op         - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                          101 SUM, 110 MAX, 111 MIN
//             vec_scalar - 1: all lanes active, 0: only lane LANES-1
//             lane_mask  - per-lane enable
//             src_a/b    - operands, lane i at [i*WIDTH +: WIDTH]
//             tag        - destination tag carried with the op
//             out_valid  - result valid
//             out_ready  - consumer accepts result
//             result     - lane results (scalar in lane LANES-1 for reductions)
//             out_tag    - tag of the result
//             flags      - {N,Z,C,V} from lane LANES-1
//  Revision : 1.0 - initial release
// ============================================================================
module vec_exec_pipe #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic                   vec_scalar,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [LANES*WIDTH-1:0] src_a,
  input  logic [LANES*WIDTH-1:0] src_b,
  input  logic [3:0]             tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [3:0]             out_tag,
  output logic [3:0]             flags
);

  localparam int LVLS  = $clog2(LANES);
  localparam int LAT   = LVLS + 1;
  // Flat tree storage: leaves at [0..LANES-1], then each level packed after
  // the previous one; the root is the last node.
  localparam int NODES = 2 * LANES - 1;
  localparam int ROOT  = NODES - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MAX = 3'b110;
  localparam logic [2:0] OP_MIN = 3'b111;

  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // Index of the first node of tree level k (level 0 = leaves).
  function automatic int lvl_base(input int k);
    return 2 * LANES - 2 * (LANES >> k);
  endfunction

  function automatic logic is_red(input logic [2:0] f_op);
    return f_op[2] & (f_op[1] | f_op[0]);
  endfunction

  // Shared adder: SUB is A + ~B + 1, so the carry-out is the ARM-style
  // "no borrow" bit.
  function automatic logic [WIDTH:0] add_ext(input logic [2:0]       f_op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] bx;
    logic             cin;
    bx  = (f_op == OP_SUB) ? ~b : b;
    cin = (f_op == OP_SUB);
    return {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  endfunction

  function automatic logic [WIDTH-1:0] lane_res(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    sum = add_ext(f_op, a, b);
    case (f_op)
      OP_ADD, OP_SUB: r = sum[WIDTH-1:0];
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_XOR:         r = a ^ b;
      default:        r = a;
    endcase
    return r;
  endfunction

  // {C,V}; only ADD/SUB produce non-zero carry/overflow.
  function automatic logic [1:0] lane_cv(input logic [2:0]       f_op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bx;
    logic [1:0]       cv;
    sum = add_ext(f_op, a, b);
    bx  = (f_op == OP_SUB) ? ~b : b;
    cv  = 2'b00;
    if (f_op == OP_ADD || f_op == OP_SUB) begin
      // Overflow: both effective operands share a sign the sum does not.
      cv = {sum[WIDTH],
            (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])};
    end
    return cv;
  endfunction

  function automatic logic [WIDTH-1:0] red_combine(input logic [2:0]       f_op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (f_op)
      OP_MAX:  r = ($signed(x) > $signed(y)) ? x : y;
      OP_MIN:  r = ($signed(x) < $signed(y)) ? x : y;
      default: r = x + y;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic                   adv;
  logic [LANES-1:0]       em;
  logic [WIDTH-1:0]       alu_res [LANES];
  logic [WIDTH-1:0]       top_a;
  logic [WIDTH-1:0]       top_b;
  logic [WIDTH-1:0]       top_res;
  logic [1:0]             top_cv;

  logic [LAT:1]           valid_d, valid_q;
  logic [2:0]             op_d    [1:LAT];
  logic [2:0]             op_q    [1:LAT];
  logic [3:0]             tag_d   [1:LAT];
  logic [3:0]             tag_q   [1:LAT];
  logic [LANES*WIDTH-1:0] ew_d    [1:LAT];
  logic [LANES*WIDTH-1:0] ew_q    [1:LAT];
  logic [3:0]             ewf_d   [1:LAT];
  logic [3:0]             ewf_q   [1:LAT];
  logic [WIDTH-1:0]       tree_d  [NODES];
  logic [WIDTH-1:0]       tree_q  [NODES];

  // The whole pipeline moves as one; a stalled output freezes every stage,
  // bubbles included, so results can never reorder or collide.
  assign adv      = !valid_q[LAT] || out_ready;
  assign in_ready = adv;

  always_comb begin
    em = lane_mask;
    if (!vec_scalar) begin
      em[LANES-2:0] = '0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign alu_res[i] = lane_res(op, src_a[i*WIDTH +: WIDTH], src_b[i*WIDTH +: WIDTH]);
  end

  assign top_a   = src_a[(LANES-1)*WIDTH +: WIDTH];
  assign top_b   = src_b[(LANES-1)*WIDTH +: WIDTH];
  assign top_res = alu_res[LANES-1];
  assign top_cv  = lane_cv(op, top_a, top_b);

  // --------------------------------------------------------------------------
  // Next-state for all stages
  // --------------------------------------------------------------------------
  always_comb begin
    // Stage 1: capture the op, elementwise results and reduction leaves.
    valid_d[1] = in_valid;
    op_d[1]    = op;
    tag_d[1]   = tag;
    for (int i = 0; i < LANES; i++) begin
      ew_d[1][i*WIDTH +: WIDTH] = em[i] ? alu_res[i] : src_a[i*WIDTH +: WIDTH];
      if (em[i]) begin
        tree_d[i] = src_a[i*WIDTH +: WIDTH];
      end else begin
        // Masked lanes feed the identity of the reduction so they cannot win.
        case (op)
          OP_MAX:  tree_d[i] = SIGNED_MIN;
          OP_MIN:  tree_d[i] = SIGNED_MAX;
          default: tree_d[i] = '0;
        endcase
      end
    end
    // A masked top lane passes A through untouched: no carry, no overflow.
    if (em[LANES-1]) begin
      ewf_d[1] = {top_res[WIDTH-1], top_res == '0, top_cv};
    end else begin
      ewf_d[1] = {top_a[WIDTH-1], top_a == '0, 2'b00};
    end

    // Stages 2..LAT: delay lines alongside the tree.
    for (int s = 2; s <= LAT; s++) begin
      valid_d[s] = valid_q[s-1];
      op_d[s]    = op_q[s-1];
      tag_d[s]   = tag_q[s-1];
      ew_d[s]    = ew_q[s-1];
      ewf_d[s]   = ewf_q[s-1];
    end

    // Tree level k is registered in stage k+1 and combines with the op that
    // stage k holds, pairing node 2j with 2j+1.
    for (int k = 1; k <= LVLS; k++) begin
      for (int j = 0; j < (LANES >> k); j++) begin
        tree_d[lvl_base(k) + j] = red_combine(op_q[k],
                                              tree_q[lvl_base(k-1) + 2*j],
                                              tree_q[lvl_base(k-1) + 2*j + 1]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int s = 1; s <= LAT; s++) begin
        op_q[s]  <= '0;
        tag_q[s] <= '0;
        ew_q[s]  <= '0;
        ewf_q[s] <= '0;
      end
      for (int n = 0; n < NODES; n++) begin
        tree_q[n] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      ew_q    <= ew_d;
      ewf_q   <= ewf_d;
      tree_q  <= tree_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output selection (purely from last-stage registers, so it holds on stall)
  // --------------------------------------------------------------------------
  assign out_valid = valid_q[LAT];
  assign out_tag   = tag_q[LAT];

  always_comb begin
    result = ew_q[LAT];
    flags  = ewf_q[LAT];
    if (is_red(op_q[LAT])) begin
      result = '0;
      result[(LANES-1)*WIDTH +: WIDTH] = tree_q[ROOT];
      flags = {tree_q[ROOT][WIDTH-1], tree_q[ROOT] == '0, 2'b00};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_exec_pipe
//  Purpose  : Scoreboard bench for vec_exec_pipe (LANES=16, WIDTH=32).
//             The driver pushes reference-model results on accept; a
//             monitor pops and compares on every output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vec_exec_pipe;

  localparam int L  = 16;
  localparam int W  = 32;
  localparam int VW = L * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic          vec_scalar = 1'b0;
  logic [L-1:0]  lane_mask = '0;
  logic [VW-1:0] src_a = '0;
  logic [VW-1:0] src_b = '0;
  logic [3:0]    tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] result;
  logic [3:0]    out_tag;
  logic [3:0]    flags;

  vec_exec_pipe #(.LANES(L), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .vec_scalar(vec_scalar), .lane_mask(lane_mask),
    .src_a(src_a), .src_b(src_b), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] res;
    logic [3:0]    tag;
    logic [3:0]    flags;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  logic bp_mode  = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain arithmetic on whole numbers, lane by lane.
  function automatic void model(input logic [2:0] f_op, input logic vs,
                                input logic [L-1:0] mask,
                                input logic [VW-1:0] a, input logic [VW-1:0] b,
                                output logic [VW-1:0] res, output logic [3:0] fl);
    logic [L-1:0] em;
    longint       x, y, xs, ys, s, acc;
    logic         c, v;
    logic [W-1:0] top;
    longint       two_w = longint'(1) << W;
    longint       smax  = (longint'(1) << (W-1)) - 1;
    longint       smin  = -(longint'(1) << (W-1));
    em = mask;
    if (!vs) em[L-2:0] = '0;
    res = a; c = 1'b0; v = 1'b0;
    if (f_op <= 3'd4) begin
      for (int i = 0; i < L; i++) begin
        if (em[i]) begin
          x  = longint'(a[i*W +: W]);
          y  = longint'(b[i*W +: W]);
          xs = longint'($signed(a[i*W +: W]));
          ys = longint'($signed(b[i*W +: W]));
          case (f_op)
            3'd0: begin
              s = x + y; res[i*W +: W] = s[W-1:0];
              if (i == L-1) begin c = (s >= two_w); v = (xs + ys > smax) || (xs + ys < smin); end
            end
            3'd1: begin
              s = x - y; res[i*W +: W] = s[W-1:0];
              if (i == L-1) begin c = (x >= y); v = (xs - ys > smax) || (xs - ys < smin); end
            end
            3'd2: res[i*W +: W] = a[i*W +: W] & b[i*W +: W];
            3'd3: res[i*W +: W] = a[i*W +: W] | b[i*W +: W];
            default: res[i*W +: W] = a[i*W +: W] ^ b[i*W +: W];
          endcase
        end
      end
    end else begin
      acc = (f_op == 3'd5) ? 0 : (f_op == 3'd6) ? smin : smax;
      for (int i = 0; i < L; i++) begin
        if (em[i]) begin
          xs = longint'($signed(a[i*W +: W]));
          if (f_op == 3'd5)      acc = acc + xs;
          else if (f_op == 3'd6) acc = (xs > acc) ? xs : acc;
          else                   acc = (xs < acc) ? xs : acc;
        end
      end
      res = '0;
      res[(L-1)*W +: W] = acc[W-1:0];
    end
    top = res[(L-1)*W +: W];
    fl  = {top[W-1], top == '0, c, v};
  endfunction

  // Present one op; push its expected response at the edge that accepts it.
  task automatic issue(input logic [2:0] f_op, input logic vs, input logic [L-1:0] m,
                       input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [3:0] t);
    exp_t          e;
    logic [VW-1:0] r;
    logic [3:0]    f;
    int            waitc;
    in_valid = 1'b1; op = f_op; vec_scalar = vs; lane_mask = m;
    src_a = a; src_b = b; tag = t;
    model(f_op, vs, m, a, b, r, f);
    e.res = r; e.flags = f; e.tag = t;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual in_ready=0 required=1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return W'($urandom());
    endcase
  endfunction

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare on every transfer, check stall stability and in_ready.
  logic [VW-1:0] h_res;
  logic [3:0]    h_tag, h_fl;
  logic          stall_prev = 1'b0;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", result, h_res);
        chk("hold_tag", out_tag, h_tag);
        chk("hold_flags", flags, h_fl);
      end
      stall_prev = out_valid && !out_ready;
      h_res = result; h_tag = out_tag; h_fl = flags;
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual tag=%0d required=none", out_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_result", result, mon_e.res);
          chk("sb_tag", out_tag, mon_e.tag);
          chk("sb_flags", flags, mon_e.flags);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] a, b;
    int            n0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_tag", out_tag, 4'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;

    // ---------------- ADD with latency check ----------------
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = W'(i);
      b[i*W +: W] = 32'hFFFF_FFFF;
    end
    issue(3'b000, 1'b1, '1, a, b, 4'h1);
    chk("lat_1", out_valid, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_%0d", k), out_valid, (k == 5));
    end
    chk("add_lane0", result[0 +: W], 32'hFFFF_FFFF);
    chk("add_lane5", result[5*W +: W], 32'h0000_0004);
    chk("add_lane15", result[15*W +: W], 32'h0000_000E);
    chk("add_flags", flags, 4'b0010);
    drain();

    // ---------------- SUM with partial / empty mask ----------------
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = W'(i + 1);
      b[i*W +: W] = W'($urandom());
    end
    issue(3'b101, 1'b1, 16'h00FF, a, b, 4'h2);
    issue(3'b101, 1'b1, 16'h0000, a, b, 4'h3);
    drain();

    // ---------------- MAX then MIN back-to-back ----------------
    a = '0;
    a[0*W +: W] = 32'hFFFF_FFFB;
    a[1*W +: W] = 32'h0000_0007;
    a[2*W +: W] = 32'h7FFF_FFFF;
    a[3*W +: W] = 32'h8000_0000;
    issue(3'b110, 1'b1, '1, a, b, 4'h4);
    issue(3'b111, 1'b1, '1, a, b, 4'h5);
    drain();

    // ---------------- scalar-mode SUB ----------------
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = 32'd9;
      b[i*W +: W] = W'($urandom());
    end
    a[15*W +: W] = 32'd0;
    b[15*W +: W] = 32'd1;
    issue(3'b001, 1'b0, '1, a, b, 4'h6);
    repeat (4) @(posedge clk);
    #1;
    chk("vs0_valid", out_valid, 1'b1);
    chk("vs0_lane15", result[15*W +: W], 32'hFFFF_FFFF);
    chk("vs0_lane0", result[0 +: W], 32'd9);
    chk("vs0_lane14", result[14*W +: W], 32'd9);
    chk("vs0_flags", flags, 4'b1000);
    drain();

    // ---------------- backpressure: 8 SUBs, consumer stalls ----------------
    n0 = n_out;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          for (int i = 0; i < L; i++) begin
            a[i*W +: W] = rval();
            b[i*W +: W] = rval();
          end
          issue(3'b001, 1'b1, 16'($urandom()), a, b, 4'(t));
        end
      end
      begin
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 8);

    // ---------------- reset mid-flight ----------------
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < L; i++) begin
        a[i*W +: W] = W'($urandom());
        b[i*W +: W] = W'($urandom());
      end
      issue(3'b000, 1'b1, '1, a, b, 4'(8 + t));
    end
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_pre_valid", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_result", result, '0);
    chk("mid_flags", flags, 4'h0);
    chk("mid_in_ready", in_ready, 1'b1);
    rst = 1'b1;
    sb.delete();
    stall_prev = 1'b0;
    n0 = n_out;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_none_emerge", n_out - n0, 0);

    // ---------------- randomized traffic ----------------
    bp_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < L; i++) begin
        a[i*W +: W] = rval();
        b[i*W +: W] = rval();
      end
      case ($urandom_range(0, 3))
        0:       lane_mask = '1;
        1:       lane_mask = '0;
        default: lane_mask = 16'($urandom());
      endcase
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), lane_mask,
            a, b, 4'($urandom_range(0, 15)));
    end
    bp_mode = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_exec_pipe.md
Name: vec_exec_pipe

Overview:
- Parametrised successor of the core's vector execute stage: LANES lanes of WIDTH bits.
- Each lane performs the same elementwise ALU op, or the whole vector is reduced with a pipelined adder/compare tree (SUM, signed MAX, signed MIN).
- Fixed latency, one operation per cycle, valid/ready backpressure, per-lane mask.
- Sits between the D/E pipeline register and the E/M register; scalar result and flags live in lane LANES-1.

Parameters:
LANES, 16, number of lanes; power of two, >= 2
WIDTH, 32, bits per lane
LAT, $clog2(LANES)+1, derived (localparam), fixed pipeline latency in cycles

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  operation presented
in_ready  output  1  pipeline can accept this cycle
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SUM, 110 MAX, 111 MIN
vec_scalar  input  1  1 = all lanes active; 0 = only lane LANES-1 active
lane_mask  input  LANES  per-lane enable; bit i gates lane i
src_a  input  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH]
src_b  input  LANES*WIDTH  operand B, same packing
tag  input  4  destination register, carried with the op
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  LANES*WIDTH  lane results
out_tag  output  4  tag of the result
flags  output  4  {N,Z,C,V} from lane LANES-1

Behaviour:
- Effective mask: em = lane_mask when vec_scalar=1; else only bit LANES-1 of lane_mask.
- Elementwise ops (000-100): result lane i = A op B when em[i]=1, else A passes through unchanged. Arithmetic wraps mod 2^WIDTH.
- SUB computes A + ~B + 1. C is the carry-out (ARM convention: C=1 means no borrow). V is signed overflow. C and V come from lane LANES-1. AND/OR/XOR set C=0, V=0.
- Reductions (101-111) operate over lanes with em=1:
  - Masked lanes contribute the identity: 0 for SUM, signed minimum for MAX, signed maximum for MIN.
  - src_b is ignored.
  - Scalar result goes to lane LANES-1; all other result lanes are 0.
  - SUM wraps mod 2^WIDTH. C=0, V=0.
  - em all zero gives the identity value.
- N = result[LANES-1] MSB. Z = (result[LANES-1] == 0).
- Pipeline structure:
  - Stage 1 registers the elementwise results, the identity-substituted reduction leaves, op, tag and valid.
  - Stages 2..LAT each register one tree level, pairing lane 2k with lane 2k+1.
  - Elementwise results and flags ride delay registers alongside the tree.
  - Every op has latency exactly LAT cycles from accept to out_valid, so results stay in issue order.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - Accept occurs when in_valid & in_ready.
  - When adv=0, all stages hold (including bubbles); inputs are not sampled.
  - When adv=1, every stage shifts; a stage's valid loads the previous stage's valid (bubbles propagate).
  - Result, out_tag and flags are held stable while out_valid & !out_ready.
- Throughput: one op per cycle with out_ready held at 1.
- Reset: async on rst=0. All valid bits clear, data registers 0. Outputs: out_valid=0, result=0, out_tag=0, flags=0. in_ready=1 during and after reset.
  - In-flight ops are discarded.
  - First accept is possible on the first rising edge with rst=1.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: output retires and input enters in the same cycle, with no bubble.

Test Plan:
(LANES=16, WIDTH=32, LAT=5)
- Reset mid-flight: three ADDs issued, rst pulled low for 1 ns between edges -> out_valid=0, result=0, flags=0 immediately; none of the three emerges later.
- ADD, vec_scalar=1, mask all ones, A lane i=i, B lane i=0xFFFFFFFF -> after 5 cycles lane0=0xFFFFFFFF, lane5=4. Lane15: 15 + 0xFFFFFFFF = 0x0000000E with C=1 and V=0, so flags N=0, Z=0, C=1, V=0.
- SUM, mask=0x00FF, A lane i=i+1 -> lane15 = 1+...+8 = 36 (0x24), other lanes 0, Z=0. Same op with mask=0 -> lane15=0, Z=1.
- MAX then MIN back-to-back, mask all ones, A = {-5, 7, 0x7FFFFFFF, -2^31, 0 ...} -> MAX gives 0x7FFFFFFF at cycle 5, MIN gives 0x80000000 at cycle 6 with N=1. out_tag follows issue order.
- Backpressure: 8 SUBs with tags 0-7, out_ready low during cycles 6-9 -> in_ready=0 in those cycles; results held stable; all 8 tags emerge in order with none lost or duplicated.
- vec_scalar=0, SUB, A lane15=0, B lane15=1, other lanes A=9 -> lane15=0xFFFFFFFF, N=1, C=0; lanes 0-14 pass through 9.
